// File: rtl/sprite_addr_gen.sv
// Multi-sprite ROM address generator: per-sprite box test against the raster,
// incrementing address counters, and hit flags delayed to line up with ROM data.
module sprite_addr_gen #(
    parameter int NUM_SPR  = 2,
    parameter int COORD_W  = 10,
    parameter int ADDR_W   = 18,
    parameter int ROM_LAT  = 1,
    parameter int V_ACTIVE = 480
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [COORD_W-1:0]         xx,
    input  logic [COORD_W-1:0]         yy,
    input  logic                       aactive,
    input  logic                       i_upd,
    input  logic [NUM_SPR-1:0]         i_en,
    input  logic [NUM_SPR*COORD_W-1:0] i_pos_x,
    input  logic [NUM_SPR*COORD_W-1:0] i_pos_y,
    input  logic [NUM_SPR*COORD_W-1:0] i_size_w,
    input  logic [NUM_SPR*COORD_W-1:0] i_size_h,
    output logic [NUM_SPR*ADDR_W-1:0]  o_addr,
    output logic [NUM_SPR-1:0]         o_on,
    output logic [2:0]                 o_sel,
    output logic                       o_any,
    output logic                       o_upd_busy
);

    logic                       w_apply;
    logic [NUM_SPR-1:0]         w_inbox;

    logic                       r_busy;
    logic [NUM_SPR-1:0]         r_pend_en;
    logic [NUM_SPR*COORD_W-1:0] r_pend_x;
    logic [NUM_SPR*COORD_W-1:0] r_pend_y;
    logic [NUM_SPR*COORD_W-1:0] r_pend_w;
    logic [NUM_SPR*COORD_W-1:0] r_pend_h;
    logic [NUM_SPR-1:0]         r_act_en;
    logic [NUM_SPR*COORD_W-1:0] r_act_x;
    logic [NUM_SPR*COORD_W-1:0] r_act_y;
    logic [NUM_SPR*COORD_W-1:0] r_act_w;
    logic [NUM_SPR*COORD_W-1:0] r_act_h;

    // Hit flags: stage 0 is the registered hit, stage ROM_LAT drives o_on.
    logic [NUM_SPR-1:0]         r_dly [ROM_LAT+1];

    // Apply point sits in vertical blanking so the active set never changes mid-frame.
    assign w_apply    = (xx == '0) && (yy == COORD_W'(V_ACTIVE));
    assign o_upd_busy = r_busy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy    <= 1'b0;
            r_pend_en <= '0;
            r_pend_x  <= '0;
            r_pend_y  <= '0;
            r_pend_w  <= '0;
            r_pend_h  <= '0;
            r_act_en  <= '0;
            r_act_x   <= '0;
            r_act_y   <= '0;
            r_act_w   <= '0;
            r_act_h   <= '0;
        end else if (i_upd && w_apply) begin
            r_act_en <= i_en;
            r_act_x  <= i_pos_x;
            r_act_y  <= i_pos_y;
            r_act_w  <= i_size_w;
            r_act_h  <= i_size_h;
            r_busy   <= 1'b0;
        end else if (i_upd) begin
            r_pend_en <= i_en;
            r_pend_x  <= i_pos_x;
            r_pend_y  <= i_pos_y;
            r_pend_w  <= i_size_w;
            r_pend_h  <= i_size_h;
            r_busy    <= 1'b1;
        end else if (w_apply && r_busy) begin
            r_act_en <= r_pend_en;
            r_act_x  <= r_pend_x;
            r_act_y  <= r_pend_y;
            r_act_w  <= r_pend_w;
            r_act_h  <= r_pend_h;
            r_busy   <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_SPR; k++) begin : g_spr
        logic [COORD_W-1:0] w_x;
        logic [COORD_W-1:0] w_y;
        logic [COORD_W-1:0] w_w;
        logic [COORD_W-1:0] w_h;
        logic [COORD_W:0]   w_x_end;
        logic [COORD_W:0]   w_y_end;
        logic [ADDR_W-1:0]  r_cnt;
        logic [ADDR_W-1:0]  r_addr;

        assign w_x = r_act_x[k*COORD_W +: COORD_W];
        assign w_y = r_act_y[k*COORD_W +: COORD_W];
        assign w_w = r_act_w[k*COORD_W +: COORD_W];
        assign w_h = r_act_h[k*COORD_W +: COORD_W];
        // One extra bit so a box touching the top of the coordinate range cannot wrap.
        assign w_x_end = {1'b0, w_x} + {1'b0, w_w};
        assign w_y_end = {1'b0, w_y} + {1'b0, w_h};

        assign w_inbox[k] = r_act_en[k] && (w_w != '0) && (w_h != '0) &&
                            (xx >= w_x) && ({1'b0, xx} < w_x_end) &&
                            (yy >= w_y) && ({1'b0, yy} < w_y_end);

        // Raster order walks the box row by row, so a counter replaces (yy-Y)*W+(xx-X).
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_cnt  <= '0;
                r_addr <= '0;
            end else begin
                if (w_inbox[k]) begin
                    r_addr <= r_cnt;
                end
                if (w_apply) begin
                    r_cnt <= '0;
                end else if (w_inbox[k]) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign o_addr[k*ADDR_W +: ADDR_W] = r_addr;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= w_inbox & {NUM_SPR{aactive}};
            for (int i = 1; i <= ROM_LAT; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign o_on  = r_dly[ROM_LAT];
    assign o_any = |o_on;

    // Scan from the top down so the lowest asserted index wins.
    always_comb begin
        o_sel = '0;
        for (int k = NUM_SPR - 1; k >= 0; k--) begin
            if (o_on[k]) begin
                o_sel = 3'(k);
            end
        end
    end

endmodule

// File: doc/sprite_addr_gen.md
# sprite_addr_gen

Parametrised multi-sprite ROM address generator for the VGA pixel pipeline. It takes the raster position from the VGA timing block and, for each of NUM_SPR rectangular sprites, produces a ROM read address and an "on" flag. Each flag is delayed to line up with that sprite's ROM output. Sprite position, size and enable are runtime-programmable through a shadow-register update applied only in vertical blanking, so sprites never tear. Addresses come from per-sprite incrementing counters, not multipliers. Output feeds the colour mux ahead of the VGA DAC.

## Interface
- NUM_SPR, 2, number of sprite channels (1..8)
- COORD_W, 10, width of raster and sprite coordinates
- ADDR_W, 18, ROM address width per sprite
- ROM_LAT, 1, ROM read latency in cycles (0..4)
- V_ACTIVE, 480, first non-active line; the update apply point is xx==0 && yy==V_ACTIVE
- i_clk  in  1  pixel clock
- i_rst  in  1  reset; asynchronous, active-high
- xx  in  COORD_W  raster x (counts through blanking)
- yy  in  COORD_W  raster y
- aactive  in  1  visible-area flag
- i_upd  in  1  one-cycle strobe; captures the i_* configuration buses below
- i_en  in  NUM_SPR  per-sprite enable
- i_pos_x, i_pos_y  in  NUM_SPR*COORD_W  top-left corner, sprite k at bits [k*COORD_W +: COORD_W]
- i_size_w, i_size_h  in  NUM_SPR*COORD_W  sprite width and height in pixels
- o_addr  out  NUM_SPR*ADDR_W  ROM address per sprite
- o_on  out  NUM_SPR  per-sprite pixel-on, aligned with ROM data
- o_sel  out  3  index of the lowest-numbered asserted o_on bit
- o_any  out  1  OR of o_on
- o_upd_busy  out  1  update captured but not yet applied

## Operation
- Three register sets: pending (written by i_upd), active (used for hit tests), and per-sprite pixel counter cnt[k] (ADDR_W bits).
- i_upd: copies all i_* buses into pending; sets o_upd_busy.
- Apply point (xx==0 && yy==V_ACTIVE):
  - If busy: pending → active; busy clears.
  - Always: every cnt[k] is cleared to 0.
- If i_upd arrives on the apply cycle, the new values go straight to active and busy stays 0.
- If i_upd arrives while busy, pending is overwritten and busy stays 1.
- In-box test for sprite k: en[k] && W>0 && H>0 && X ≤ xx < X+W && Y ≤ yy < Y+H.
  - X+W and Y+H are computed at COORD_W+1 bits, so there is no wrap.
  - W==0 or H==0 means sprite k never hits.
- When in-box (aactive ignored): o_addr[k] ← cnt[k]; cnt[k] ← cnt[k]+1, wrapping at 2^ADDR_W.
  - Raster order therefore yields (yy−Y)·W + (xx−X) with no multiplier.
  - Because the count does not depend on aactive, sprites clipped into horizontal blanking still address correctly.
- When not in-box, o_addr[k] holds its value.
- hit[k] = in-box && aactive, registered once. o_on[k] is that registered hit delayed by a further ROM_LAT register stages.
- o_sel and o_any are combinational from o_on; lowest index has highest priority. With no hit, o_sel = 0 and o_any = 0.

## Timing
- Raster sample at cycle t gives o_addr at t+1 and o_on / o_sel / o_any at t+1+ROM_LAT.
- This matches the ROM data for the address presented at t+1.
- Configuration takes effect from the apply cycle onward: the first hit test using the new values is the cycle after apply.
- Reset (asynchronous, any time including mid-frame):
  - o_addr=0, o_on=0, o_sel=0, o_any=0, o_upd_busy=0.
  - All pending, active and cnt registers = 0, so all sprites are disabled.
  - Delay-line stages are cleared.
- After reset release, nothing is drawn until an i_upd followed by an apply point.
- Overlapping sprites: every o_on bit is asserted independently; only o_sel applies priority.

## Test plan
- Single sprite, X=80 Y=112 W=471 H=250, ROM_LAT=1; update then full frame:
  - o_on[0] first asserts 2 cycles after (80,112) with o_addr=0.
  - Address is 470 at (550,112) and 471 at (80,113).
  - Last address 117749; o_on asserts exactly 117750 times per frame.
- Two overlapping sprites, sprite 0 at (100,100,50,50) and sprite 1 at (120,120,50,50):
  - At (130,130), o_on=2'b11, o_sel=0, o_any=1.
  - At (160,160), o_on=2'b10, o_sel=1.
- Mid-frame i_upd moving X from 80 to 200 at yy=200:
  - o_upd_busy=1 until (0,480); the remainder of that frame still draws at X=80.
  - The next frame draws at X=200.
- Right-edge clip, X=600 W=100 (640 active, xx counts to 799):
  - At (600,Y+1), o_addr = 100.
  - o_on is 0 for xx ≥ 640.
- Asynchronous reset asserted mid-sprite at (300,200):
  - All outputs are 0 within the same cycle and stay 0 through the following full frame with no update.
- ROM_LAT=3 and W=0 on sprite 1:
  - o_on[0] lags the o_addr change by exactly 3 cycles.
  - o_on[1] never asserts.
